uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive stage at the far end of the link driven by the transmitter block.
//  Synchronises serial_in, detects and validates the start bit, and samples DATA_LENGTH bits LSB-first at mid-bit.
//  Checks the stop bit, then presents the byte on a valid/ready handshake to the downstream consumer.
// PARAMETERS
//  DATA_LENGTH  8  data bits per frame, LSB first
//  BIT_PERIOD   5  clocks per bit; legal minimum 3
//  HALF         (BIT_PERIOD-1)/2  derived localparam; mid-bit offset
// PORTS
//  clk        in   1            system clock, all logic on posedge
//  prst       in   1            reset, synchronous, active-high
//  serial_in  in   1            asynchronous serial line, idle high
//  rx_ready   in   1            consumer accepts rx_data this cycle
//  rx_data    out  DATA_LENGTH  received byte, stable while rx_valid=1
//  rx_valid   out  1            byte available; held until accepted
//  frame_err  out  1            1-cycle pulse: stop bit sampled 0
//  overrun    out  1            sticky: byte dropped because holding register was full
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0; FSM=IDLE; counters=0; sync flops=1.
//   Reset mid-frame aborts the frame; a partial byte is never delivered.
//  Synchroniser: 2 flops; s = second flop. The FSM sees only s.
//  FSM states and transitions:
//   IDLE:  s==0 -> START, cnt=0.
//   START: cnt increments. At cnt==HALF: s==0 -> DATA, cnt=0, bit_idx=0; s==1 -> IDLE (glitch, no flags).
//   DATA:  cnt increments. At cnt==BIT_PERIOD-1: shift_reg[bit_idx]=s, cnt=0, bit_idx++.
//          After DATA_LENGTH samples -> STOP.
//   STOP:  at cnt==BIT_PERIOD-1, sample s.
//          s==1 -> deliver, then IDLE.
//          s==0 -> frame_err=1 for exactly the next cycle, byte discarded, -> BREAK.
//   BREAK: wait for s==1, then IDLE. Prevents a held-low line from retriggering.
//  Sampling: each data/stop sample falls one BIT_PERIOD after the previous one (start midpoint + k*BIT_PERIOD).
//  Latency: rx_valid rises 4+HALF+(DATA_LENGTH+1)*BIT_PERIOD cycles after serial_in falls. Default = 51.
//  Handshake:
//   Transfer occurs on any cycle with rx_valid&rx_ready; rx_valid drops on the next cycle unless a new byte is delivered.
//   Deliver with rx_valid=0, or with rx_valid&rx_ready in the same cycle: load rx_data, rx_valid=1, no overrun.
//   Deliver with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun=1.
//   overrun stays set until prst.
//   rx_ready while rx_valid=0 has no effect.
//  Counters: cnt width $clog2(BIT_PERIOD); bit_idx width $clog2(DATA_LENGTH+1). Neither wraps in use.
//  All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE, START, DATA, STOP, BREAK), 3-bit state type, default DATA_LENGTH/BIT_PERIOD.
//  One sub-module: uart_rx_sync (2-flop synchroniser, reset value 1).
//  FSM, counters, shift register and output holding register stay in this module.
// TESTING (defaults: DATA_LENGTH=8, BIT_PERIOD=5)
//  1. Frame 0xA5 with correct stop, rx_ready=1 -> rx_valid pulses 51 cycles after the start edge; rx_data=0xA5; flags 0.
//  2. serial_in low for 1 cycle, then high -> FSM returns to IDLE; no rx_valid, no frame_err.
//  3. Frame 0x3C with stop bit 0, line held low 20 cycles -> one frame_err pulse, no rx_valid; no new frame until line high.
//  4. rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, overrun=1;
//     assert rx_ready -> 0x11 accepted, rx_valid=0.
//  5. Back-to-back frames 0x00, 0xFF, 0x5A with rx_ready=1 -> three rx_valid pulses with the correct data; overrun=0.
//  6. prst asserted mid-DATA of 0x77, line then idles -> outputs 0, no rx_valid;
//     next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   state_t                    3-bit FSM state type
//   ST_IDLE .. ST_BREAK        state encodings
//   DATA_LENGTH_DEF            default data bits per frame
//   BIT_PERIOD_DEF             default clocks per bit
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  localparam int DATA_LENGTH_DEF = 8;
  localparam int BIT_PERIOD_DEF  = 5;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser bringing the asynchronous serial line into the
// clk domain. Both flops reset to 1 so the line reads as idle after reset.
// Ports:
//   clk       in   system clock
//   prst      in   synchronous active-high reset
//   serial_i  in   asynchronous serial line
//   sync_o    out  synchronised line (second flop)
module uart_rx_sync (
  input  logic clk,
  input  logic prst,
  input  logic serial_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (prst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= serial_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: synchronises the serial line, validates the start
// bit at its midpoint, samples DATA_LENGTH bits LSB-first one bit period
// apart, checks the stop bit and offers the byte on a valid/ready handshake.
// Ports:
//   clk        in   system clock
//   prst       in   synchronous active-high reset
//   serial_in  in   asynchronous serial line, idle high
//   rx_ready   in   consumer accepts rx_data this cycle
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  byte available, held until accepted
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   overrun    out  sticky: a byte was dropped because rx_data was still held
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int BIT_PERIOD  = BIT_PERIOD_DEF
) (
  input  logic                   clk,
  input  logic                   prst,
  input  logic                   serial_in,
  input  logic                   rx_ready,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int HALF  = (BIT_PERIOD - 1) / 2;
  localparam int CNT_W = $clog2(BIT_PERIOD);
  localparam int IDX_W = $clog2(DATA_LENGTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LENGTH - 1);

  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_LENGTH-1:0] shift_q, shift_d;
  logic [DATA_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   deliver;

  uart_rx_sync u_sync (
    .clk      (clk),
    .prst     (prst),
    .serial_i (serial_in),
    .sync_o   (s)
  );

  // Frame FSM. Bits enter at the MSB and shift right, so after DATA_LENGTH
  // samples the first (LSB) bit has arrived at bit 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            // Start bit gone by its midpoint: treat as a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {s, shift_q[DATA_LENGTH-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a stuck-low line
        // cannot immediately look like a new start bit.
        if (s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register and handshake. A byte arriving while the previous one
  // is still unaccepted is dropped and flagged; an accept in the same cycle
  // frees the register in time for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Shift register is pure datapath: every bit is overwritten before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int DL = 8;
  localparam int BP = 5;

  logic          clk;
  logic          prst;
  logic          serial_in;
  logic          rx_ready;
  logic [DL-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;

  int n_tests;
  int n_fail;

  int          cyc;
  int          t_start;
  int          rise_cnt;
  int          rise_cyc;
  int          ferr_cnt;
  logic        valid_prev;
  logic [7:0]  rise_q[$];

  uart_receiver #(.DATA_LENGTH(DL), .BIT_PERIOD(BP)) dut (
    .clk       (clk),
    .prst      (prst),
    .serial_in (serial_in),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: records rx_valid rising edges and frame_err cycles.
  initial begin
    rise_cnt   = 0;
    rise_cyc   = 0;
    ferr_cnt   = 0;
    valid_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && valid_prev !== 1'b1) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
      rise_q.push_back(rx_data);
    end
    if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    valid_prev = rx_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a clock edge; returns just after the edge that ends
  // the stop bit, so consecutive calls produce back-to-back frames.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_start   = cyc;
    serial_in = 1'b0;
    step(BP);
    for (int i = 0; i < DL; i++) begin
      serial_in = d[i];
      step(BP);
    end
    serial_in = stop;
    step(BP);
  endtask

  task automatic test_reset;
    prst      = 1'b1;
    serial_in = 1'b1;
    rx_ready  = 1'b0;
    step(3);
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    prst = 1'b0;
    step(3);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rx_valid: got %b expected 0", rx_valid); end
  endtask

  task automatic test_frame;
    int rb, fb;
    rb = rise_cnt; fb = ferr_cnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    step(3);
    n_tests++; if (rise_cnt - rb !== 1) begin n_fail++; $display("FAIL frame_valid_count: got %0d expected 1", rise_cnt - rb); end
    n_tests++; if (rise_cyc - t_start !== 51) begin n_fail++; $display("FAIL frame_latency: got %0d expected 51", rise_cyc - t_start); end
    if (rise_cnt - rb >= 1) begin
      n_tests++; if (rise_q[rb] !== 8'hA5) begin n_fail++; $display("FAIL frame_data: got %h expected a5", rise_q[rb]); end
    end
    n_tests++; if (ferr_cnt - fb !== 0) begin n_fail++; $display("FAIL frame_ferr: got %0d expected 0", ferr_cnt - fb); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL frame_overrun: got %b expected 0", overrun); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL frame_accepted: got %b expected 0", rx_valid); end
  endtask

  task automatic test_glitch;
    int rb, fb;
    rb = rise_cnt; fb = ferr_cnt;
    serial_in = 1'b0;
    step(1);
    serial_in = 1'b1;
    step(60);
    n_tests++; if (rise_cnt - rb !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", rise_cnt - rb); end
    n_tests++; if (ferr_cnt - fb !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - fb); end
    send_frame(8'hC3, 1'b1);
    step(3);
    n_tests++; if (rise_cnt - rb !== 1) begin n_fail++; $display("FAIL glitch_recover_count: got %0d expected 1", rise_cnt - rb); end
    if (rise_cnt - rb >= 1) begin
      n_tests++; if (rise_q[rb] !== 8'hC3) begin n_fail++; $display("FAIL glitch_recover_data: got %h expected c3", rise_q[rb]); end
    end
  endtask

  task automatic test_frame_err;
    int rb, fb;
    rb = rise_cnt; fb = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    step(20);
    n_tests++; if (ferr_cnt - fb !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - fb); end
    n_tests++; if (rise_cnt - rb !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", rise_cnt - rb); end
    serial_in = 1'b1;
    step(60);
    n_tests++; if (ferr_cnt - fb !== 1) begin n_fail++; $display("FAIL break_ferr: got %0d expected 1", ferr_cnt - fb); end
    n_tests++; if (rise_cnt - rb !== 0) begin n_fail++; $display("FAIL break_valid: got %0d expected 0", rise_cnt - rb); end
    send_frame(8'h96, 1'b1);
    step(3);
    n_tests++; if (rise_cnt - rb !== 1) begin n_fail++; $display("FAIL break_recover_count: got %0d expected 1", rise_cnt - rb); end
    if (rise_cnt - rb >= 1) begin
      n_tests++; if (rise_q[rb] !== 8'h96) begin n_fail++; $display("FAIL break_recover_data: got %h expected 96", rise_q[rb]); end
    end
  endtask

  task automatic test_back_to_back;
    int rb;
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h5A;
    rb = rise_cnt;
    rx_ready = 1'b1;
    for (int k = 0; k < 3; k++) send_frame(exp[k], 1'b1);
    step(3);
    n_tests++; if (rise_cnt - rb !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", rise_cnt - rb); end
    for (int k = 0; k < 3; k++) begin
      if (rise_cnt - rb > k) begin
        n_tests++; if (rise_q[rb+k] !== exp[k]) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", k, rise_q[rb+k], exp[k]); end
      end
    end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun;
    int rb;
    rb = rise_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(3);
    n_tests++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_rx_data: got %h expected 11", rx_data); end
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_rx_valid: got %b expected 1", rx_valid); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    n_tests++; if (rise_cnt - rb !== 1) begin n_fail++; $display("FAIL ovr_valid_count: got %0d expected 1", rise_cnt - rb); end
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b expected 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_kept: got %h expected 11", rx_data); end
    step(5);
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid_frame;
    int rb, fb;
    logic [7:0] d;
    d = 8'h77;
    rx_ready = 1'b1;
    serial_in = 1'b0;
    step(BP);
    for (int i = 0; i < 3; i++) begin
      serial_in = d[i];
      step(BP);
    end
    serial_in = 1'b1;
    prst = 1'b1;
    step(2);
    prst = 1'b0;
    rb = rise_cnt; fb = ferr_cnt;
    step(60);
    n_tests++; if (rise_cnt - rb !== 0) begin n_fail++; $display("FAIL rstmid_valid_count: got %0d expected 0", rise_cnt - rb); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
    n_tests++; if (ferr_cnt - fb !== 0) begin n_fail++; $display("FAIL rstmid_ferr: got %0d expected 0", ferr_cnt - fb); end
    send_frame(8'h81, 1'b1);
    step(3);
    n_tests++; if (rise_cnt - rb !== 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d expected 1", rise_cnt - rb); end
    if (rise_cnt - rb >= 1) begin
      n_tests++; if (rise_q[rb] !== 8'h81) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected 81", rise_q[rb]); end
    end
    n_tests++; if (rise_cyc - t_start !== 51) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d expected 51", rise_cyc - t_start); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    prst      = 1'b1;
    serial_in = 1'b1;
    rx_ready  = 1'b0;
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
